sr_ccu_seq: RTL
===============

// Module: sr_ccu_seq
// PURPOSE
//  Parametrised multi-cycle coprocessor unit for the sr_cpu core. Accepts one op
//  (bounded count, shift-add multiply, restoring unsigned divide/remainder),
//  iterates in WORK, then presents result + dest reg on a valid/ready
//  writeback port. The core stalls its PC while busy=1 and uses wb_valid to
//  steer the register-file write port.
// PARAMETERS
//  WIDTH     32    operand/result width
//  RD_W      5     destination register tag width
//  MAX_ITER  1024  COUNT iteration cap; exceeding it terminates with overflow=1
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, asynchronous, active-high
//  start     in   1      op request; accepted only in IDLE
//  oper      in   2      00 COUNT, 01 MUL, 10 DIVU, 11 REMU (sampled with start)
//  rd_i      in   RD_W   destination register tag (sampled with start)
//  srcA      in   WIDTH  operand A (COUNT start / multiplicand / dividend)
//  srcB      in   WIDTH  operand B (COUNT limit / multiplier / divisor)
//  abort     in   1      cancel in-flight op, no writeback
//  busy      out  1      1 whenever state != IDLE
//  wb_valid  out  1      result held for writeback (state DONE)
//  wb_ready  in   1      core accepts writeback this cycle
//  wb_rd     out  RD_W   latched rd_i
//  result    out  WIDTH  op result, stable while wb_valid
//  zero      out  1      result == 0
//  sign      out  1      result[WIDTH-1]
//  carry     out  1      COUNT: counter wrapped past all-ones; MUL: high half != 0
//  overflow  out  1      COUNT: MAX_ITER hit; DIVU/REMU: divisor == 0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  - Reset (any time, incl. mid-op): state=IDLE; busy, wb_valid, carry,
//    overflow = 0; result = 0, wb_rd = 0 (so zero=1, sign=0). No writeback.
//  - FSM IDLE -> WORK on start=1 (edge samples oper/rd_i/srcA/srcB).
//    WORK -> DONE on op termination; DONE -> IDLE on wb_valid & wb_ready.
//    abort=1 in WORK or DONE -> IDLE next edge, no writeback; abort beats
//    wb_ready and termination. abort in IDLE ignored.
//  - start while not IDLE ignored (no queueing); core must not issue it.
//  - COUNT: counter=srcA, iter=0. Each WORK cycle: if counter==srcB -> DONE,
//    result=counter; else if iter==MAX_ITER-1 -> DONE, result=counter,
//    overflow=1; else counter+=1 mod 2^WIDTH (sticky carry on wrap to 0), iter+=1.
//    WORK cycles = min((srcB-srcA) mod 2^WIDTH + 1, MAX_ITER).
//  - MUL: WIDTH WORK cycles, LSB-first shift-add, 2*WIDTH accumulator;
//    result = low WIDTH bits, carry = |high half. overflow=0.
//  - DIVU/REMU: WIDTH WORK cycles restoring division, one quotient bit/cycle;
//    result = quotient (DIVU) or remainder (REMU). Divisor 0: exactly 1 WORK
//    cycle, DIVU result = all-ones, REMU result = srcA, overflow=1.
//  - Latency: start at edge t -> busy=1 from t+1 -> wb_valid=1 at t+1+N
//    (N = WORK cycles above). Earliest new start accepted = edge after handoff.
//  - wb_valid stays 1, result/wb_rd/flags frozen, until wb_ready sampled 1.
//  - Flags are cleared on start acceptance; zero/sign purely combinational on result.
// TESTING
//  1 COUNT srcA=3 srcB=5 rd_i=7, wb_ready=1 -> 3 busy WORK cycles, wb_valid at
//    t+4, result=5 wb_rd=7 carry=0 overflow=0, busy=0 at t+5.
//  2 COUNT srcA=0xFFFFFFFE srcB=1, MAX_ITER=1024 -> 4 WORK cycles, result=1,
//    carry=1; srcA=0 srcB=5000 -> result=1023, overflow=1 after 1024 cycles.
//  3 MUL 0x10000 x 0x10003 -> wb_valid at t+33, result=0x00030000, carry=1;
//    MUL 7 x 6 -> result=42, carry=0, zero=0.
//  4 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> result=0xFFFFFFFF,
//    overflow=1, wb_valid at t+2; REMU 5/0 -> result=5.
//  5 Hold wb_ready=0 for 10 cycles in DONE with start pulsing -> result/wb_rd
//    stable, start ignored, single writeback when wb_ready=1.
//  6 abort at WORK cycle 10 of MUL, and rst pulse mid-DIVU -> IDLE next edge
//    (rst: immediately), no wb_valid; follow-up COUNT 0->0 gives result=0, zero=1.

Source files
------------

// File: rtl/sr_ccu_if.sv
// Request/writeback bundle between the sr_cpu core (master) and the
// multi-cycle coprocessor unit (slave).
interface sr_ccu_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
);
  logic             start;
  logic [1:0]       oper;
  logic [RD_W-1:0]  rd_i;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             abort;
  logic             busy;
  logic             wb_valid;
  logic             wb_ready;
  logic [RD_W-1:0]  wb_rd;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             sign;
  logic             carry;
  logic             overflow;

  modport master (
    output start, oper, rd_i, srcA, srcB, abort, wb_ready,
    input  busy, wb_valid, wb_rd, result, zero, sign, carry, overflow
  );

  modport slave (
    input  start, oper, rd_i, srcA, srcB, abort, wb_ready,
    output busy, wb_valid, wb_rd, result, zero, sign, carry, overflow
  );
endinterface

// File: rtl/sr_ccu_seq.sv
// Multi-cycle coprocessor: bounded COUNT, shift-add MUL, restoring DIVU/REMU.
// One op in flight; result is held on a valid/ready writeback port.
module sr_ccu_seq #(
  parameter int WIDTH    = 32,
  parameter int RD_W     = 5,
  parameter int MAX_ITER = 1024
) (
  input  logic       clk,
  input  logic       rst,
  sr_ccu_if.slave    bus
);

  localparam int ITER_MAX = (MAX_ITER > WIDTH) ? MAX_ITER : WIDTH;
  localparam int ITER_W   = $clog2(ITER_MAX) + 1;

  typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;
  typedef enum logic [1:0] {OP_COUNT = 2'b00, OP_MUL = 2'b01,
                            OP_DIVU = 2'b10, OP_REMU = 2'b11} op_t;

  state_t state, state_nxt;
  op_t    op;

  logic [ITER_W-1:0]  iter;
  logic [RD_W-1:0]    rd;
  logic [WIDTH-1:0]   result;
  logic               carry;
  logic               overflow;

  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   limit;
  logic               wrap;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   divisor;

  logic               fin;
  logic               fin_ok;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_carry;
  logic               fin_ovf;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] div_res;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               accept;

  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [2*WIDTH-1:0] acc_in,
    input logic [2*WIDTH-1:0] mcand_in,
    input logic               bit_in
  );
    return bit_in ? (acc_in + mcand_in) : acc_in;
  endfunction

  // One restoring-division step: returns {remainder, quotient} after shifting
  // in the next dividend bit and conditionally subtracting the divisor.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem_in,
    input logic [WIDTH-1:0] quo_in,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    sh    = {rem_in, quo_in[WIDTH-1]};
    trial = sh - {1'b0, dvs};
    if (!trial[WIDTH])
      return {trial[WIDTH-1:0], quo_in[WIDTH-2:0], 1'b1};
    else
      return {sh[WIDTH-1:0], quo_in[WIDTH-2:0], 1'b0};
  endfunction

  assign accept   = (state == IDLE) && bus.start;
  assign acc_step = mul_step(acc, mcand, mplier[0]);
  assign div_res  = div_step(rem, quo, divisor);
  assign rem_step = div_res[2*WIDTH-1:WIDTH];
  assign quo_step = div_res[WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    fin        = 1'b0;
    fin_result = cnt;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_nxt = WORK;
      WORK: begin
        unique case (op)
          OP_COUNT: begin
            fin_carry = wrap;
            if (cnt == limit) begin
              fin = 1'b1;
            end else if (iter == ITER_W'(MAX_ITER - 1)) begin
              fin     = 1'b1;
              fin_ovf = 1'b1;
            end
          end
          OP_MUL: begin
            fin_result = acc_step[WIDTH-1:0];
            fin_carry  = |acc_step[2*WIDTH-1:WIDTH];
            fin        = (iter == ITER_W'(WIDTH - 1));
          end
          default: begin
            // Zero divisor finishes on the first WORK cycle; quo still holds
            // the untouched dividend at that point.
            if (divisor == '0) begin
              fin        = 1'b1;
              fin_ovf    = 1'b1;
              fin_result = (op == OP_DIVU) ? '1 : quo;
            end else begin
              fin        = (iter == ITER_W'(WIDTH - 1));
              fin_result = (op == OP_DIVU) ? quo_step : rem_step;
            end
          end
        endcase
        if (fin) state_nxt = DONE;
      end
      DONE: if (bus.wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && (state != IDLE)) state_nxt = IDLE;
  end

  assign fin_ok = fin && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= OP_COUNT;
      iter     <= '0;
      rd       <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op       <= op_t'(bus.oper);
        rd       <= bus.rd_i;
        iter     <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
      end else if (state == WORK) begin
        iter <= iter + ITER_W'(1);
        if (fin_ok) begin
          result   <= fin_result;
          carry    <= fin_carry;
          overflow <= fin_ovf;
        end
      end
    end
  end

  // Iteration datapath: loaded on accept, stepped every WORK cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt     <= bus.srcA;
      limit   <= bus.srcB;
      wrap    <= 1'b0;
      mcand   <= {{WIDTH{1'b0}}, bus.srcA};
      mplier  <= bus.srcB;
      acc     <= '0;
      quo     <= bus.srcA;
      rem     <= '0;
      divisor <= bus.srcB;
    end else if (state == WORK) begin
      unique case (op)
        OP_COUNT: begin
          cnt <= cnt + WIDTH'(1);
          if (cnt == '1) wrap <= 1'b1;
        end
        OP_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        default: begin
          quo <= quo_step;
          rem <= rem_step;
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.wb_valid = (state == DONE);
  assign bus.wb_rd    = rd;
  assign bus.result   = result;
  assign bus.zero     = (result == '0);
  assign bus.sign     = result[WIDTH-1];
  assign bus.carry    = carry;
  assign bus.overflow = overflow;

endmodule
